mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, sets how many back-to-back data-port grants are allowed while fetch waits.
REQ-002 clk  input  1  rising-edge clock; one clock domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch read request.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch request accepted by memory.
REQ-007 if_rvalid  output  1  one-cycle pulse: if_rdata valid.
REQ-008 if_rdata  output  32  fetch read data.
REQ-009 dm_req  input  1  data-stage request.
REQ-010 dm_we  input  1  1 = write, 0 = read.
REQ-011 dm_addr  input  32  data byte address.
REQ-012 dm_wdata  input  32  write data.
REQ-013 dm_gnt / dm_rvalid / dm_rdata  output  1/1/32  same meaning as the fetch port equivalents.
REQ-014 mem_req / mem_we  output  1/1  request and write-enable to the shared single-port memory.
REQ-015 mem_addr / mem_wdata  output  32/32  memory address and write data.
REQ-016 mem_ready  input  1  memory accepts mem_req in this cycle.
REQ-017 mem_rvalid / mem_rdata  input  1/32  read response.
REQ-018 busy  output  1  FSM is not in IDLE.
REQ-019 err_spurious  output  1  sticky: mem_rvalid was seen outside WAIT.

Function
REQ-020 The FSM SHALL have exactly three states, IDLE, ISSUE and WAIT, and only one memory transaction SHALL be outstanding at any time.
REQ-021 IDLE with a request present: pick the owner, latch owner, we, addr and wdata into registers, go to ISSUE next cycle.
REQ-022 Fetch-port captures SHALL always latch we = 0 and wdata = 0.
REQ-023 Priority when both requests are high in IDLE:
- dm wins by default;
- if wins when starve_cnt == STARVE_LIMIT.
REQ-024 starve_cnt behaviour:
- +1 (saturating at STARVE_LIMIT) on each dm capture while if_req = 1;
- cleared on an if capture;
- cleared on a dm capture while if_req = 0.
REQ-025 ISSUE outputs: mem_req = 1 and mem_we/mem_addr/mem_wdata driven from the latched values, held stable until mem_ready = 1.
REQ-026 On the ISSUE cycle where mem_ready = 1, the owner's gnt SHALL pulse high in that same cycle (combinational from state and mem_ready).
REQ-027 ISSUE exit: a write returns to IDLE, a read goes to WAIT.
REQ-028 Outside ISSUE, mem_req SHALL be 0, and mem_addr/mem_we/mem_wdata SHALL hold the last latched values.
REQ-029 In WAIT, on mem_rvalid = 1:
- register mem_rdata into the owner's rdata;
- pulse the owner's rvalid on the next cycle;
- return to IDLE.
REQ-030 if_rdata/dm_rdata SHALL hold their value until that port's next response; the other port's rdata/rvalid SHALL be unaffected.
REQ-031 Timing from a request seen in IDLE at cycle t:
- mem_req high at t+1;
- with mem_ready = 1 at t+1 and mem_rvalid at t+2, rvalid pulses at t+3 and a new capture is possible at t+3;
- a write with mem_ready = 1 at t+1 returns to IDLE at t+2.
REQ-032 Transactions SHALL NOT be cancellable; a request dropped after capture still completes, and its gnt/rvalid are still pulsed.
REQ-033 Requesters SHALL hold req and payload until gnt; the arbiter SHALL NOT re-sample payload after capture.
REQ-034 A request arriving while busy = 1 SHALL wait; IDLE SHALL evaluate arbitration in the same cycle WAIT or ISSUE exits to it.
REQ-035 mem_rvalid in IDLE or ISSUE: set err_spurious and discard the data; no rvalid pulse.

Reset
REQ-036 On a clock edge with reset = 1, the following SHALL all be 0 on the next cycle:
- state = IDLE; starve_cnt, owner and latched we/addr/wdata;
- mem_req, mem_we, mem_addr, mem_wdata;
- if_gnt, dm_gnt, if_rvalid, dm_rvalid;
- if_rdata, dm_rdata, busy, err_spurious.
REQ-037 reset SHALL take priority over all other inputs, and reset mid-transaction SHALL abandon it with no gnt or rvalid pulse; a later stale mem_rvalid sets err_spurious per REQ-035.

Verification
REQ-038 Single fetch: if_req = 1, if_addr = 0x100, mem_ready = 1 immediately, mem_rvalid with 0x00500093 two cycles after capture -> if_gnt at t+1, if_rdata = 0x00500093 and if_rvalid at t+3, dm outputs unchanged.
REQ-039 Data write with backpressure: dm_req = 1, dm_we = 1, dm_addr = 0x2000, dm_wdata = 0xDEADBEEF, mem_ready low for 3 cycles -> mem_req/addr/wdata stable for 4 cycles, dm_gnt only in the 4th, no rvalid, IDLE the next cycle.
REQ-040 Starvation: if_req held high, dm_req reads back-to-back, STARVE_LIMIT = 4 -> exactly 4 dm grants, then 1 if grant, then dm resumes.
REQ-041 Simultaneous requests with starve_cnt = 0 -> dm served first; if captured in the cycle WAIT exits to IDLE.
REQ-042 Reset in WAIT, then mem_rvalid two cycles later -> no rvalid pulse on either port, err_spurious = 1, busy = 0.
REQ-043 mem_rvalid pulsed in IDLE with no request -> err_spurious = 1 and stays 1 until reset; rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and shared-memory signals around the arbiter.
// The arbiter takes the slave view; the requesters plus memory take the master view.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        err_spurious;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, busy, err_spurious
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
           mem_ready, mem_rvalid, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, busy, err_spurious
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port memory with one
// outstanding transaction; data wins by default, fetch is protected from starvation.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             owner_if;
  logic             lat_we;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [CNT_W-1:0] starve_cnt;

  logic             capture;
  logic             pick_if;
  logic             accept;

  logic             if_rvalid_q;
  logic             dm_rvalid_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      dm_rdata_q;
  logic             err_q;

  always_comb begin
    pick_if = bus.if_req && (!bus.dm_req || (starve_cnt == LIMIT));
    capture = (state == IDLE) && (bus.if_req || bus.dm_req);
    accept  = (state == ISSUE) && bus.mem_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (capture) state_nxt = ISSUE;
      ISSUE:   if (accept) state_nxt = lat_we ? IDLE : WAIT;
      WAIT:    if (bus.mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grants are combinational so the requester sees acceptance in the memory's ready cycle.
  always_comb begin
    bus.mem_req      = (state == ISSUE);
    bus.mem_we       = lat_we;
    bus.mem_addr     = lat_addr;
    bus.mem_wdata    = lat_wdata;
    bus.if_gnt       = accept && owner_if;
    bus.dm_gnt       = accept && !owner_if;
    bus.busy         = (state != IDLE);
    bus.if_rvalid    = if_rvalid_q;
    bus.dm_rvalid    = dm_rvalid_q;
    bus.if_rdata     = if_rdata_q;
    bus.dm_rdata     = dm_rdata_q;
    bus.err_spurious = err_q;
  end

  // Payload is taken once at capture and never re-sampled, so a dropped request still completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_if   <= 1'b0;
      lat_we     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      starve_cnt <= '0;
    end else if (capture) begin
      owner_if <= pick_if;
      if (pick_if) begin
        lat_we     <= 1'b0;
        lat_addr   <= bus.if_addr;
        lat_wdata  <= '0;
        starve_cnt <= '0;
      end else begin
        lat_we    <= bus.dm_we;
        lat_addr  <= bus.dm_addr;
        lat_wdata <= bus.dm_wdata;
        if (!bus.if_req)             starve_cnt <= '0;
        else if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  // A response outside WAIT has no owner (e.g. left over from a reset) and is only flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if (bus.mem_rvalid) begin
        if (state == WAIT) begin
          if (owner_if) begin
            if_rdata_q  <= bus.mem_rdata;
            if_rvalid_q <= 1'b1;
          end else begin
            dm_rdata_q  <= bus.mem_rdata;
            dm_rvalid_q <= 1'b1;
          end
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cycle checks plus a
// read-data scoreboard fed at request time and drained on each rvalid pulse.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  int          gnt_log[$];
  int          exp_seq[6] = '{0, 0, 0, 0, 1, 0};

  int ready_stall = 0;
  int rsp_delay   = 1;
  bit inject_rv   = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Memory model: optional ready stall, read response rsp_delay cycles after acceptance.
  initial begin
    logic [31:0] mem_model [logic [31:0]];
    int          wcnt;
    int          pend;
    logic [31:0] pend_data;
    wcnt = 0;
    pend = 0;
    pend_data = '0;
    mem_model[32'h100] = 32'h0050_0093;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rvalid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = pend_data;
        end
      end
      if (inject_rv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hBAD0_BAD0;
      end
      if (bus.mem_req) begin
        if (wcnt < ready_stall) begin
          bus.mem_ready = 1'b0;
          wcnt++;
        end else begin
          bus.mem_ready = 1'b1;
          wcnt = 0;
          if (bus.mem_we) mem_model[bus.mem_addr] = bus.mem_wdata;
          else begin
            pend      = rsp_delay;
            pend_data = mem_model.exists(bus.mem_addr) ? mem_model[bus.mem_addr]
                                                       : exp_rd(bus.mem_addr);
          end
        end
      end else begin
        bus.mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Response monitor: every rvalid pulse must match the oldest expectation of its port.
  always @(negedge clk) begin
    if (bus.if_gnt) gnt_log.push_back(1);
    if (bus.dm_gnt) gnt_log.push_back(0);
    if (bus.if_gnt && bus.dm_gnt) check("dual_gnt", {bus.if_gnt, bus.dm_gnt}, 2'b10);
    if (bus.if_rvalid) begin
      if (exp_if_q.size() == 0) check("if_rvalid_unexpected", bus.if_rvalid, 0);
      else check("if_rdata_sb", bus.if_rdata, exp_if_q.pop_front());
    end
    if (bus.dm_rvalid) begin
      if (exp_dm_q.size() == 0) check("dm_rvalid_unexpected", bus.dm_rvalid, 0);
      else check("dm_rdata_sb", bus.dm_rdata, exp_dm_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic dm_read(input logic [31:0] a, input logic [31:0] e);
    bit got;
    got = 1'b0;
    nc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = a; bus.dm_wdata = '0;
    exp_dm_q.push_back(e);
    for (int c = 0; c < 40 && !got; c++) begin
      neg();
      got = bus.dm_gnt;
      nc();
    end
    bus.dm_req = 1'b0;
    check("dm_read_gnt", got, 1);
    repeat (3) nc();
  endtask

  initial begin
    bit g_if, g_dm;
    int dm_issued;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // Reset state
    repeat (3) nc();
    neg();
    check("rst_busy", bus.busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_gnts", {bus.if_gnt, bus.dm_gnt}, 0);
    check("rst_rvalids", {bus.if_rvalid, bus.dm_rvalid}, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    check("rst_err", bus.err_spurious, 0);
    nc();
    reset = 1'b0;

    // Single fetch read
    nc();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    exp_if_q.push_back(32'h0050_0093);
    neg();
    check("t1_busy_idle", bus.busy, 0);
    nc(); neg();
    check("t1_mem_req", bus.mem_req, 1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    check("t1_mem_we", bus.mem_we, 0);
    check("t1_if_gnt", bus.if_gnt, 1);
    check("t1_dm_gnt", bus.dm_gnt, 0);
    nc(); bus.if_req = 1'b0; neg();
    check("t1_busy_wait", bus.busy, 1);
    check("t1_mem_req_off", bus.mem_req, 0);
    check("t1_if_rvalid_early", bus.if_rvalid, 0);
    nc(); neg();
    check("t1_if_rvalid", bus.if_rvalid, 1);
    check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
    check("t1_dm_rvalid", bus.dm_rvalid, 0);
    check("t1_dm_rdata", bus.dm_rdata, 0);
    check("t1_busy_done", bus.busy, 0);

    // Data write with three stall cycles; payload changes mid-flight must not leak through
    ready_stall = 3;
    nc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      nc();
      if (k == 2) begin
        bus.dm_addr  = 32'hFFFF_0000;
        bus.dm_wdata = 32'h1234_5678;
      end
      neg();
      check($sformatf("t2_mem_req_%0d", k), bus.mem_req, 1);
      check($sformatf("t2_mem_addr_%0d", k), bus.mem_addr, 32'h2000);
      check($sformatf("t2_mem_wdata_%0d", k), bus.mem_wdata, 32'hDEAD_BEEF);
      check($sformatf("t2_mem_we_%0d", k), bus.mem_we, 1);
      check($sformatf("t2_dm_gnt_%0d", k), bus.dm_gnt, (k == 4) ? 1 : 0);
    end
    nc(); bus.dm_req = 1'b0; bus.dm_we = 1'b0; neg();
    check("t2_busy_after", bus.busy, 0);
    check("t2_mem_req_after", bus.mem_req, 0);
    check("t2_mem_addr_hold", bus.mem_addr, 32'h2000);
    check("t2_mem_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
    check("t2_dm_rvalid", bus.dm_rvalid, 0);
    ready_stall = 0;
    dm_read(32'h2000, 32'hDEAD_BEEF);

    // Starvation: fetch held high while data issues five back-to-back reads
    gnt_log.delete();
    nc();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    exp_if_q.push_back(exp_rd(32'h300));
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1000;
    exp_dm_q.push_back(exp_rd(32'h1000));
    dm_issued = 1;
    for (int c = 0; c < 200 && (bus.dm_req || bus.if_req); c++) begin
      neg();
      g_if = bus.if_gnt;
      g_dm = bus.dm_gnt;
      nc();
      if (g_if) bus.if_req = 1'b0;
      if (g_dm) begin
        if (dm_issued < 5) begin
          bus.dm_addr = 32'h1000 + 32'(4 * dm_issued);
          exp_dm_q.push_back(exp_rd(bus.dm_addr));
          dm_issued++;
        end else begin
          bus.dm_req = 1'b0;
        end
      end
    end
    check("t3_done", {bus.if_req, bus.dm_req}, 0);
    repeat (4) nc();
    check("t3_log_len", gnt_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_gnt_%0d", i), (i < gnt_log.size()) ? gnt_log[i] : 7, exp_seq[i]);

    // Simultaneous requests: data first, fetch captured as WAIT returns to IDLE
    nc();
    bus.if_req = 1'b1; bus.if_addr = 32'h104; exp_if_q.push_back(exp_rd(32'h104));
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400; exp_dm_q.push_back(exp_rd(32'h400));
    nc(); neg();
    check("t4_dm_gnt", bus.dm_gnt, 1);
    check("t4_if_gnt_first", bus.if_gnt, 0);
    check("t4_mem_addr_dm", bus.mem_addr, 32'h400);
    nc(); bus.dm_req = 1'b0; neg();
    nc(); neg();
    check("t4_dm_rvalid", bus.dm_rvalid, 1);
    check("t4_busy_idle", bus.busy, 0);
    nc(); neg();
    check("t4_if_gnt", bus.if_gnt, 1);
    check("t4_mem_addr_if", bus.mem_addr, 32'h104);
    nc(); bus.if_req = 1'b0; neg();
    nc(); neg();
    check("t4_if_rvalid", bus.if_rvalid, 1);

    // Request dropped right after capture still completes with gnt and rvalid
    ready_stall = 2;
    nc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h600; exp_dm_q.push_back(exp_rd(32'h600));
    nc(); bus.dm_req = 1'b0; bus.dm_addr = '0; neg();
    check("t5_mem_req", bus.mem_req, 1);
    check("t5_mem_addr", bus.mem_addr, 32'h600);
    check("t5_dm_gnt_stall", bus.dm_gnt, 0);
    nc(); neg();
    nc(); neg();
    check("t5_dm_gnt", bus.dm_gnt, 1);
    repeat (3) nc();
    ready_stall = 0;

    // Spurious response in IDLE: sticky error, read data untouched
    neg(); inject_rv = 1'b1;
    nc(); neg(); inject_rv = 1'b0;
    nc(); neg();
    check("t7_err", bus.err_spurious, 1);
    check("t7_if_rdata", bus.if_rdata, exp_rd(32'h104));
    check("t7_dm_rdata", bus.dm_rdata, exp_rd(32'h600));
    check("t7_busy", bus.busy, 0);
    repeat (5) nc();
    neg();
    check("t7_err_sticky", bus.err_spurious, 1);

    // Reset while waiting for a read, stale response arrives afterwards
    rsp_delay = 3;
    nc();
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
    nc(); neg();
    check("t6_dm_gnt", bus.dm_gnt, 1);
    nc(); bus.dm_req = 1'b0; reset = 1'b1; neg();
    check("t6_busy_wait", bus.busy, 1);
    nc(); reset = 1'b0; neg();
    check("t6_busy_rst", bus.busy, 0);
    check("t6_err_rst", bus.err_spurious, 0);
    check("t6_dm_rdata_rst", bus.dm_rdata, 0);
    check("t6_if_rdata_rst", bus.if_rdata, 0);
    nc(); neg();
    check("t6_stale_seen", bus.mem_rvalid, 1);
    nc(); neg();
    check("t6_err", bus.err_spurious, 1);
    check("t6_rvalids", {bus.if_rvalid, bus.dm_rvalid}, 0);
    check("t6_busy", bus.busy, 0);
    rsp_delay = 1;

    nc(); reset = 1'b1;
    nc(); reset = 1'b0; neg();
    check("fin_err_clear", bus.err_spurious, 0);
    check("fin_if_q_empty", exp_if_q.size(), 0);
    check("fin_dm_q_empty", exp_dm_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
